// File: rtl/sap_control_unit_if.sv
// Bundle of the SAP-U control-unit signals: opcode/flags in, step/halt status and control strobes out.
interface sap_control_unit_if;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    logic [2:0] step;
    logic       halted;
    logic       hlt;
    logic       mi_n;
    logic       ri_n;
    logic       ro_n;
    logic       ii_n;
    logic       io_n;
    logic       ai_n;
    logic       ao_n;
    logic       bi_n;
    logic       eo_n;
    logic       su;
    logic       fi_n;
    logic       oi_n;
    logic       ce;
    logic       co_n;
    logic       j_n;

    // No valid/ready handshake: opcode and flags are level inputs read every cycle,
    // and every strobe is a combinational level valid for the whole current T-state.
    modport master (
        input  opcode, carry_flag, zero_flag,
        output step, halted, hlt, mi_n, ri_n, ro_n, ii_n, io_n, ai_n, ao_n,
               bi_n, eo_n, su, fi_n, oi_n, ce, co_n, j_n
    );

    modport slave (
        output opcode, carry_flag, zero_flag,
        input  step, halted, hlt, mi_n, ri_n, ro_n, ii_n, io_n, ai_n, ao_n,
               bi_n, eo_n, su, fi_n, oi_n, ce, co_n, j_n
    );
endinterface

// File: rtl/sap_control_unit.sv
// SAP-U microcode sequencer: T-state counter, halt latch and opcode/flag decode into the control word.
module sap_control_unit #(
    parameter int NUM_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic clk,
    input  logic clr,
    sap_control_unit_if.master bus
);

    localparam logic [2:0] T0   = 3'd0;
    localparam logic [2:0] T1   = 3'd1;
    localparam logic [2:0] T2   = 3'd2;
    localparam logic [2:0] T3   = 3'd3;
    localparam logic [2:0] T4   = 3'd4;
    localparam logic [2:0] LAST = 3'(NUM_STEPS - 1);

    localparam int C_HLT = 15;
    localparam int C_MI  = 14;
    localparam int C_RI  = 13;
    localparam int C_RO  = 12;
    localparam int C_II  = 11;
    localparam int C_IO  = 10;
    localparam int C_AI  = 9;
    localparam int C_AO  = 8;
    localparam int C_BI  = 7;
    localparam int C_EO  = 6;
    localparam int C_SU  = 5;
    localparam int C_FI  = 4;
    localparam int C_OI  = 3;
    localparam int C_CE  = 2;
    localparam int C_CO  = 1;
    localparam int C_J   = 0;

    logic [2:0]  r_step;
    logic        r_halted;
    logic [15:0] w_act;
    logic        w_empty;

    // Decode is held in active-high form; the bus-facing polarity is applied at the outputs.
    always_comb begin
        w_act = '0;
        if (clr) begin
            w_act = '0;
        end else if (r_halted) begin
            w_act[C_HLT] = 1'b1;
        end else begin
            case (r_step)
                T0: begin
                    w_act[C_CO] = 1'b1;
                    w_act[C_MI] = 1'b1;
                end
                T1: begin
                    w_act[C_RO] = 1'b1;
                    w_act[C_II] = 1'b1;
                    w_act[C_CE] = 1'b1;
                end
                T2: begin
                    case (bus.opcode)
                        4'h1, 4'h2, 4'h3, 4'h4: begin
                            w_act[C_IO] = 1'b1;
                            w_act[C_MI] = 1'b1;
                        end
                        4'h5: begin
                            w_act[C_IO] = 1'b1;
                            w_act[C_AI] = 1'b1;
                        end
                        4'h6: begin
                            w_act[C_IO] = 1'b1;
                            w_act[C_J]  = 1'b1;
                        end
                        4'h7: begin
                            w_act[C_IO] = bus.carry_flag;
                            w_act[C_J]  = bus.carry_flag;
                        end
                        4'h8: begin
                            w_act[C_IO] = bus.zero_flag;
                            w_act[C_J]  = bus.zero_flag;
                        end
                        4'hE: begin
                            w_act[C_AO] = 1'b1;
                            w_act[C_OI] = 1'b1;
                        end
                        4'hF: w_act[C_HLT] = 1'b1;
                        default: ;
                    endcase
                end
                T3: begin
                    case (bus.opcode)
                        4'h1: begin
                            w_act[C_RO] = 1'b1;
                            w_act[C_AI] = 1'b1;
                        end
                        4'h2, 4'h3: begin
                            w_act[C_RO] = 1'b1;
                            w_act[C_BI] = 1'b1;
                        end
                        4'h4: begin
                            w_act[C_AO] = 1'b1;
                            w_act[C_RI] = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (bus.opcode == 4'h2 || bus.opcode == 4'h3) begin
                        w_act[C_EO] = 1'b1;
                        w_act[C_AI] = 1'b1;
                        w_act[C_FI] = 1'b1;
                        w_act[C_SU] = (bus.opcode == 4'h3);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_empty = (w_act == 16'h0000);

    // A halting T2 word latches halted and leaves the step parked at T2.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_step   <= T0;
            r_halted <= 1'b0;
        end else if (!r_halted) begin
            if (w_act[C_HLT]) begin
                r_halted <= 1'b1;
            end else if (r_step == LAST) begin
                r_step <= T0;
            end else if (EARLY_END && (r_step >= T2) && w_empty) begin
                r_step <= T0;
            end else begin
                r_step <= r_step + 3'd1;
            end
        end
    end

    assign bus.step   = r_step;
    assign bus.halted = r_halted;
    assign bus.hlt    = w_act[C_HLT];
    assign bus.mi_n   = ~w_act[C_MI];
    assign bus.ri_n   = ~w_act[C_RI];
    assign bus.ro_n   = ~w_act[C_RO];
    assign bus.ii_n   = ~w_act[C_II];
    assign bus.io_n   = ~w_act[C_IO];
    assign bus.ai_n   = ~w_act[C_AI];
    assign bus.ao_n   = ~w_act[C_AO];
    assign bus.bi_n   = ~w_act[C_BI];
    assign bus.eo_n   = ~w_act[C_EO];
    assign bus.su     = w_act[C_SU];
    assign bus.fi_n   = ~w_act[C_FI];
    assign bus.oi_n   = ~w_act[C_OI];
    assign bus.ce     = w_act[C_CE];
    assign bus.co_n   = ~w_act[C_CO];
    assign bus.j_n    = ~w_act[C_J];

endmodule

// File: tb/tb_sap_control_unit.sv
// Directed-vector bench for sap_control_unit: one EARLY_END=1 and one EARLY_END=0 instance share clk/clr.
module tb_sap_control_unit;

    logic clk = 1'b0;
    logic clr = 1'b1;

    always #5 clk = ~clk;

    sap_control_unit_if bus_e ();
    sap_control_unit_if bus_n ();

    sap_control_unit #(.NUM_STEPS(5), .EARLY_END(1'b1)) dut_e (
        .clk (clk),
        .clr (clr),
        .bus (bus_e)
    );

    sap_control_unit #(.NUM_STEPS(5), .EARLY_END(1'b0)) dut_n (
        .clk (clk),
        .clr (clr),
        .bus (bus_n)
    );

    // Active-high word encoding used by the bench's expectations.
    localparam logic [15:0] W_HLT = 16'h8000;
    localparam logic [15:0] W_MI  = 16'h4000;
    localparam logic [15:0] W_RI  = 16'h2000;
    localparam logic [15:0] W_RO  = 16'h1000;
    localparam logic [15:0] W_II  = 16'h0800;
    localparam logic [15:0] W_IO  = 16'h0400;
    localparam logic [15:0] W_AI  = 16'h0200;
    localparam logic [15:0] W_AO  = 16'h0100;
    localparam logic [15:0] W_BI  = 16'h0080;
    localparam logic [15:0] W_EO  = 16'h0040;
    localparam logic [15:0] W_SU  = 16'h0020;
    localparam logic [15:0] W_FI  = 16'h0010;
    localparam logic [15:0] W_OI  = 16'h0008;
    localparam logic [15:0] W_CE  = 16'h0004;
    localparam logic [15:0] W_CO  = 16'h0002;
    localparam logic [15:0] W_J   = 16'h0001;
    localparam logic [15:0] F0    = W_CO | W_MI;
    localparam logic [15:0] F1    = W_RO | W_II | W_CE;

    logic [19:0] exp_q[$];
    logic [2:0]  exp_n_q[$];
    int n_vec = 0;
    int n_err = 0;

    initial begin
        bus_e.opcode = 4'h0; bus_e.carry_flag = 1'b0; bus_e.zero_flag = 1'b0;
        bus_n.opcode = 4'h0; bus_n.carry_flag = 1'b0; bus_n.zero_flag = 1'b0;
    end

    function automatic logic [15:0] word_e();
        return {bus_e.hlt, ~bus_e.mi_n, ~bus_e.ri_n, ~bus_e.ro_n, ~bus_e.ii_n, ~bus_e.io_n,
                ~bus_e.ai_n, ~bus_e.ao_n, ~bus_e.bi_n, ~bus_e.eo_n, bus_e.su, ~bus_e.fi_n,
                ~bus_e.oi_n, bus_e.ce, ~bus_e.co_n, ~bus_e.j_n};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue what that cycle must show.
    task automatic v(input logic [3:0] op, input logic c, input logic z, input logic r,
                     input logic chk, input logic [2:0] es, input logic eh, input logic [15:0] ew,
                     input logic cn, input logic [2:0] esn);
        @(posedge clk);
        #1;
        clr = r;
        bus_e.opcode = op; bus_e.carry_flag = c; bus_e.zero_flag = z;
        bus_n.opcode = op; bus_n.carry_flag = c; bus_n.zero_flag = z;
        if (chk) exp_q.push_back({es, eh, ew});
        if (cn) exp_n_q.push_back(esn);
    endtask

    task automatic e(input logic [3:0] op, input logic c, input logic z,
                     input logic [2:0] es, input logic [15:0] ew);
        v(op, c, z, 1'b0, 1'b1, es, 1'b0, ew, 1'b0, 3'd0);
    endtask

    task automatic en(input logic [3:0] op, input logic [2:0] es, input logic [15:0] ew,
                      input logic [2:0] esn);
        v(op, 1'b0, 1'b0, 1'b0, 1'b1, es, 1'b0, ew, 1'b1, esn);
    endtask

    task automatic rst(input logic [3:0] op);
        v(op, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b1, 3'd0);
    endtask

    logic [19:0] mon_e;
    logic [2:0]  mon_n;
    logic [4:0]  mon_be;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("step_e", 16'(bus_e.step), 16'(mon_e[19:17]));
            check("halted_e", 16'(bus_e.halted), 16'(mon_e[16]));
            check("word_e", word_e(), mon_e[15:0]);
        end
        if (exp_n_q.size() > 0) begin
            mon_n = exp_n_q.pop_front();
            check("step_n", 16'(bus_n.step), 16'(mon_n));
        end
        mon_be = ~{bus_e.ro_n, bus_e.io_n, bus_e.ao_n, bus_e.eo_n, bus_e.co_n};
        check("bus_excl_e", 16'($countones(mon_be) > 1), 16'd0);
        mon_be = ~{bus_n.ro_n, bus_n.io_n, bus_n.ao_n, bus_n.eo_n, bus_n.co_n};
        check("bus_excl_n", 16'($countones(mon_be) > 1), 16'd0);
    end

    logic [2:0]  nop_s[6];
    logic [15:0] nop_w[6];

    initial begin
        nop_s = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        nop_w = '{F0, F1, 16'h0000, F0, F1, 16'h0000};

        rst(4'h2);
        rst(4'h2);
        // ADD then SUB: identical step sequences for both instances
        en(4'h2, 3'd0, F0, 3'd0);
        en(4'h2, 3'd1, F1, 3'd1);
        en(4'h2, 3'd2, W_IO | W_MI, 3'd2);
        en(4'h2, 3'd3, W_RO | W_BI, 3'd3);
        en(4'h2, 3'd4, W_EO | W_AI | W_FI, 3'd4);
        en(4'h3, 3'd0, F0, 3'd0);
        en(4'h3, 3'd1, F1, 3'd1);
        en(4'h3, 3'd2, W_IO | W_MI, 3'd2);
        en(4'h3, 3'd3, W_RO | W_BI, 3'd3);
        en(4'h3, 3'd4, W_EO | W_AI | W_FI | W_SU, 3'd4);
        // LDA interrupted by clr just after reaching T3: clear must be immediate
        en(4'h1, 3'd0, F0, 3'd0);
        en(4'h1, 3'd1, F1, 3'd1);
        en(4'h1, 3'd2, W_IO | W_MI, 3'd2);
        rst(4'h1);
        // LDI: early end after empty T3 versus full five steps
        en(4'h5, 3'd0, F0, 3'd0);
        en(4'h5, 3'd1, F1, 3'd1);
        en(4'h5, 3'd2, W_IO | W_AI, 3'd2);
        en(4'h5, 3'd3, 16'h0000, 3'd3);
        en(4'h5, 3'd0, F0, 3'd4);
        en(4'h5, 3'd1, F1, 3'd0);
        rst(4'h4);
        e(4'h4, 0, 0, 3'd0, F0);
        e(4'h4, 0, 0, 3'd1, F1);
        e(4'h4, 0, 0, 3'd2, W_IO | W_MI);
        e(4'h4, 0, 0, 3'd3, W_AO | W_RI);
        e(4'h4, 0, 0, 3'd4, 16'h0000);
        // JC not taken (zero set must not matter), then taken
        e(4'h7, 0, 1, 3'd0, F0);
        e(4'h7, 0, 1, 3'd1, F1);
        e(4'h7, 0, 1, 3'd2, 16'h0000);
        e(4'h7, 1, 0, 3'd0, F0);
        e(4'h7, 1, 0, 3'd1, F1);
        e(4'h7, 1, 0, 3'd2, W_IO | W_J);
        e(4'h7, 1, 0, 3'd3, 16'h0000);
        // JZ: flag rising only at T2 is seen in the same cycle; then not taken with carry set
        e(4'h8, 0, 0, 3'd0, F0);
        e(4'h8, 0, 0, 3'd1, F1);
        e(4'h8, 0, 1, 3'd2, W_IO | W_J);
        e(4'h8, 0, 1, 3'd3, 16'h0000);
        e(4'h8, 1, 0, 3'd0, F0);
        e(4'h8, 1, 0, 3'd1, F1);
        e(4'h8, 1, 0, 3'd2, 16'h0000);
        e(4'hE, 0, 0, 3'd0, F0);
        e(4'hE, 0, 0, 3'd1, F1);
        e(4'hE, 0, 0, 3'd2, W_AO | W_OI);
        e(4'hE, 0, 0, 3'd3, 16'h0000);
        e(4'h0, 0, 0, 3'd0, F0);
        e(4'h0, 0, 0, 3'd1, F1);
        e(4'h0, 0, 0, 3'd2, 16'h0000);
        e(4'hB, 1, 1, 3'd0, F0);
        e(4'hB, 1, 1, 3'd1, F1);
        e(4'hB, 1, 1, 3'd2, 16'h0000);
        e(4'h6, 0, 0, 3'd0, F0);
        e(4'h6, 0, 0, 3'd1, F1);
        e(4'h6, 0, 0, 3'd2, W_IO | W_J);
        e(4'h6, 0, 0, 3'd3, 16'h0000);
        e(4'h1, 0, 0, 3'd0, F0);
        e(4'h1, 0, 0, 3'd1, F1);
        e(4'h1, 0, 0, 3'd2, W_IO | W_MI);
        e(4'h1, 0, 0, 3'd3, W_RO | W_AI);
        e(4'h1, 0, 0, 3'd4, 16'h0000);
        // HLT: parked at T2; a changed opcode while halted must not leak into the word
        e(4'hF, 0, 0, 3'd0, F0);
        e(4'hF, 0, 0, 3'd1, F1);
        e(4'hF, 0, 0, 3'd2, W_HLT);
        for (int i = 0; i < 10; i++)
            v((i < 5) ? 4'hF : 4'h2, 1'b1, 1'b1, 1'b0, 1'b1, 3'd2, 1'b1, W_HLT, 1'b0, 3'd0);
        v(4'hF, 0, 0, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 3'd0);
        e(4'hF, 0, 0, 3'd0, F0);
        // Sweep every opcode and flag pair; 0x9..0xD must match the NOP sequence
        for (int op = 0; op < 16; op++) begin
            for (int fl = 0; fl < 4; fl++) begin
                v(4'(op), fl[1], fl[0], 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 3'd0);
                for (int s = 0; s < 6; s++)
                    v(4'(op), fl[1], fl[0], 1'b0, (op >= 9 && op <= 13), nop_s[s], 1'b0,
                      nop_w[s], 1'b0, 3'd0);
            end
        end
        @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0 || exp_n_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d/%0d expectations left unchecked", exp_q.size(), exp_n_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sap_control_unit.md
Name: sap_control_unit

Overview:
- Microcode sequencer for the SAP-U 8-bit bus computer.
- Steps a T-state counter and decodes the instruction-register opcode and ALU flags into the control word.
- The control word drives every register's load and bus-enable strobes, the RAM, the program counter and the ALU.
- It decides who drives the shared 8-bit bus each cycle, so it is the bus arbiter for all 8-bit registers.

Parameters:
- NUM_STEPS, 5, T-states per instruction before forced wrap to T0; legal values 5..8.
- EARLY_END, 1, when 1, a T-state at or above T2 whose decoded control word is all-inactive ends the instruction (next step = T0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- clr  input  1  reset, asynchronous, active-high; clears step counter and halt latch.
- opcode  input  4  instruction register q[7:4].
- carry_flag  input  1  latched ALU carry from the flags register.
- zero_flag  input  1  latched ALU zero from the flags register.
- step  output  3  current T-state (0..NUM_STEPS-1).
- halted  output  1  halt latch state.
- hlt  output  1  clock-halt request, active-high.
- mi_n  output  1  MAR load, active-low.
- ri_n  output  1  RAM write, active-low.
- ro_n  output  1  RAM bus enable, active-low.
- ii_n  output  1  IR load, active-low.
- io_n  output  1  IR operand bus enable, active-low.
- ai_n  output  1  A register load, active-low.
- ao_n  output  1  A register bus enable, active-low.
- bi_n  output  1  B register load, active-low.
- eo_n  output  1  ALU bus enable, active-low.
- su  output  1  ALU subtract, active-high.
- fi_n  output  1  flags load, active-low.
- oi_n  output  1  output register load, active-low.
- ce  output  1  PC count enable, active-high.
- co_n  output  1  PC bus enable, active-low.
- j_n  output  1  PC jump load, active-low.

Behaviour:
- State is a 3-bit step counter plus a 1-bit halt latch.
- Control outputs are combinational from (step, opcode, flags, halted, clr).
- "Inactive" means all _n outputs = 1 and ce, su, hlt = 0.
- While clr = 1, all control outputs are inactive. Step and halted read 0.
- After clr is released, step = 0, so the T0 word is driven.
- Fetch, every opcode:
  - T0: co_n, mi_n.
  - T1: ro_n, ii_n, ce.
- Execute words (only listed signals active):
  - 0x0 NOP: none.
  - 0x1 LDA: T2 io_n, mi_n; T3 ro_n, ai_n.
  - 0x2 ADD: T2 io_n, mi_n; T3 ro_n, bi_n; T4 eo_n, ai_n, fi_n.
  - 0x3 SUB: same as ADD, plus su at T4 only.
  - 0x4 STA: T2 io_n, mi_n; T3 ao_n, ri_n.
  - 0x5 LDI: T2 io_n, ai_n.
  - 0x6 JMP: T2 io_n, j_n.
  - 0x7 JC: T2 io_n, j_n if carry_flag = 1, else none.
  - 0x8 JZ: T2 io_n, j_n if zero_flag = 1, else none.
  - 0xE OUT: T2 ao_n, oi_n.
  - 0xF HLT: T2 hlt.
  - 0x9..0xD: treated as NOP.
- Step advance, on each rising edge with halted = 0:
  - If step = NUM_STEPS-1, next step = 0.
  - Else if EARLY_END = 1, step >= 2 and the current word is all-inactive, next step = 0.
  - Otherwise next step = step + 1.
- Halt:
  - At the rising edge where the T2 word has hlt = 1, halted is set to 1 and step freezes at 2.
  - While halted = 1: hlt = 1, all other controls inactive, step frozen.
  - Only clr leaves the halted state.
- Flags are sampled combinationally during T2. A flag change mid-T2 changes j_n in the same cycle; the value at the rising edge governs EARLY_END.
- Bus exclusivity: at most one of ro_n, io_n, ao_n, eo_n, co_n is low in any cycle. Every decoded word must satisfy this.
- Reset mid-instruction: asynchronous clear to step 0. The next instruction fetches from whatever address the PC holds; the PC is reset independently.
- Opcode is assumed stable from T2 onward, since ii_n is active only in T1.

Test Plan:
- Reset: clr = 1 with step = 3 -> step = 0 and all controls inactive immediately, with no clock edge. Release clr -> co_n = 0, mi_n = 0.
- ADD, opcode = 0x2, EARLY_END = 1:
  - Step sequence is 0,1,2,3,4,0.
  - At T4: eo_n = 0, ai_n = 0, fi_n = 0, su = 0.
  - The bus enable is unique in every cycle.
- LDI, opcode = 0x5, EARLY_END = 1 -> step sequence 0,1,2,3,0: T3 is empty, so the instruction terminates early. With EARLY_END = 0 -> 0,1,2,3,4,0.
- JC with carry_flag = 0 -> T2 word inactive, and step goes 2 -> 0. With carry_flag = 1 -> io_n = 0 and j_n = 0 at T2, then step 3, then 0.
- HLT, opcode = 0xF:
  - At T2, hlt = 1.
  - After the edge, halted = 1 and step stays 2 for 10 further clocks, with hlt held at 1 and all other controls inactive.
  - Pulse clr -> halted = 0 and step = 0.
- Sweep all 16 opcodes with all 4 flag combinations and every step -> no cycle has two bus enables low, and opcodes 0x9..0xD behave exactly as NOP.
